// File: rtl/reg_serial_reader.sv
// Captures a parallel register word on start and streams it LSB-first over a
// ready/valid single-bit channel, optionally followed by an even-parity bit.
module reg_serial_reader #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_bit_last;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shift_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_xfer;
    logic             w_data_end;
    logic             w_frame_end;

    assign w_shift_next = r_shift >> 1;
    assign w_cnt_next   = r_cnt + CW'(1);
    assign w_xfer       = r_bit_valid && bit_ready;
    assign w_data_end   = (r_state == ST_SEND) && (r_cnt == LAST_IDX);
    // The frame ends on the last data bit only when no parity trailer follows.
    assign w_frame_end  = w_xfer && ((w_data_end && !PARITY_EN) || (r_state == ST_PARITY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_frame_end) begin
                r_state     <= ST_IDLE;
                r_bit_out   <= 1'b0;
                r_bit_valid <= 1'b0;
                r_bit_last  <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_shift     <= din;
                            r_par       <= ^din;
                            r_cnt       <= '0;
                            r_state     <= ST_SEND;
                            r_bit_out   <= din[0];
                            r_bit_valid <= 1'b1;
                            r_bit_last  <= !PARITY_EN && (WIDTH == 1);
                            r_busy      <= 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (w_xfer) begin
                            if (w_data_end) begin
                                r_state    <= ST_PARITY;
                                r_bit_out  <= r_par;
                                r_bit_last <= 1'b1;
                            end else begin
                                r_shift    <= w_shift_next;
                                r_cnt      <= w_cnt_next;
                                r_bit_out  <= w_shift_next[0];
                                r_bit_last <= !PARITY_EN && (w_cnt_next == LAST_IDX);
                            end
                        end
                    end
                    ST_PARITY: begin
                        // Transfer of the parity bit is handled by w_frame_end.
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_last  = r_bit_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_serial_reader.sv
// Bench for reg_serial_reader: a parity and a no-parity instance share stimulus and
// are checked against a queue-based frame model, a frame table and directed corner cases.
module tb_reg_serial_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic        bit_ready;

    logic p_out, p_valid, p_last, p_busy, p_done;
    logic n_out, n_valid, n_last, n_busy, n_done;

    int checks = 0;
    int errors = 0;

    reg_serial_reader #(.WIDTH(16), .PARITY_EN(1'b1)) dut_p (
        .clk(clk), .rst(rst), .start(start), .din(din), .bit_ready(bit_ready),
        .bit_out(p_out), .bit_valid(p_valid), .bit_last(p_last), .busy(p_busy), .done(p_done)
    );

    reg_serial_reader #(.WIDTH(16), .PARITY_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start(start), .din(din), .bit_ready(bit_ready),
        .bit_out(n_out), .bit_valid(n_valid), .bit_last(n_last), .busy(n_busy), .done(n_done)
    );

    always #5 clk = ~clk;

    // Reference model: each in-flight frame is just the queue of bits still to send.
    bit qp[$];
    bit qn[$];
    bit mdp = 1'b0;
    bit mdn = 1'b0;
    bit junk;

    always @(posedge clk) begin
        if (rst) begin
            qp.delete();
            qn.delete();
            mdp = 1'b0;
            mdn = 1'b0;
        end else begin
            mdp = 1'b0;
            mdn = 1'b0;
            if (qp.size() > 0) begin
                if (bit_ready) begin
                    junk = qp.pop_front();
                    mdp  = (qp.size() == 0);
                end
            end else if (start) begin
                for (int i = 0; i < 16; i++) qp.push_back(din[i]);
                qp.push_back(^din);
            end
            if (qn.size() > 0) begin
                if (bit_ready) begin
                    junk = qn.pop_front();
                    mdn  = (qn.size() == 0);
                end
            end else if (start) begin
                for (int i = 0; i < 16; i++) qn.push_back(din[i]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("p_valid", 32'(p_valid), 32'(qp.size() > 0));
        chk("p_out", 32'(p_out), 32'((qp.size() > 0) ? qp[0] : 1'b0));
        chk("p_last", 32'(p_last), 32'(qp.size() == 1));
        chk("p_busy", 32'(p_busy), 32'(qp.size() > 0));
        chk("p_done", 32'(p_done), 32'(mdp));
        chk("n_valid", 32'(n_valid), 32'(qn.size() > 0));
        chk("n_out", 32'(n_out), 32'((qn.size() > 0) ? qn[0] : 1'b0));
        chk("n_last", 32'(n_last), 32'(qn.size() == 1));
        chk("n_busy", 32'(n_busy), 32'(qn.size() > 0));
        chk("n_done", 32'(n_done), 32'(mdn));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Runs one frame on the parity instance, optionally stalling at a bit index and
    // poking start mid-frame; returns the transferred bits and the done cycle.
    task automatic run_frame(input logic [15:0] d, input int stall_at, input int stall_len,
                             input bit poke, output logic [16:0] bits, output int nb,
                             output int dcyc);
        int idx     = 0;
        int stalled = 0;
        bits = '0;
        nb   = 0;
        dcyc = -1;
        start     = 1'b1;
        din       = d;
        bit_ready = 1'b1;
        step();
        chk("first_bit_valid", 32'(p_valid), 32'd1);
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            bit_ready = !(idx == stall_at && stalled < stall_len);
            if (!bit_ready) stalled++;
            start = poke && (idx == 4 || idx == 10);
            din   = poke ? 16'hFFFF : 16'($urandom);
            if (p_done) dcyc = c;
            else if (p_valid && bit_ready && nb < 17) begin
                bits[nb] = p_out;
                nb++;
                idx++;
            end
            step();
        end
        start     = 1'b0;
        bit_ready = 1'b1;
        chk("done_one_cycle", 32'(p_done), 32'd0);
        chk("idle_after_done", 32'(p_busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0] din;
        logic        par;
    } frame_vec_t;

    frame_vec_t  vecs[7];
    logic [16:0] bits;
    int          nb;
    int          dcyc;

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0};
        vecs[1] = '{16'h0001, 1'b1};
        vecs[2] = '{16'hFFFF, 1'b0};
        vecs[3] = '{16'h00F0, 1'b0};
        vecs[4] = '{16'h8000, 1'b1};
        vecs[5] = '{16'h0000, 1'b0};
        vecs[6] = '{16'h7FFF, 1'b1};

        rst = 1'b1; start = 1'b0; din = '0; bit_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 32'({p_valid, n_valid}), 32'd0);
        chk("rst_out", 32'({p_out, n_out}), 32'd0);
        chk("rst_busy_done_last", 32'({p_busy, p_done, p_last, n_busy, n_done, n_last}), 32'd0);
        rst = 1'b0;
        step();

        // Frame table, free-running ready
        foreach (vecs[k]) begin
            run_frame(vecs[k].din, -1, 0, 1'b0, bits, nb, dcyc);
            chk("tbl_nbits", 32'(nb), 32'd17);
            chk("tbl_bits", 32'(bits), 32'({vecs[k].par, vecs[k].din}));
            chk("tbl_done_cycle", 32'(dcyc), 32'd18);
        end

        // Backpressure on bit 5 for three cycles
        run_frame(16'hA5C3, 5, 3, 1'b0, bits, nb, dcyc);
        chk("bp_bits", 32'(bits), 32'h0A5C3);
        chk("bp_done_cycle", 32'(dcyc), 32'd21);

        // Bit 5 held unchanged across a stall
        start = 1'b1; din = 16'hA5C3; step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", 32'({p_valid, p_out, p_last}), 32'b100);
        end
        bit_ready = 1'b1;
        step();
        chk("bp_resume_bit6", 32'({p_valid, p_out}), 32'b11);
        for (int i = 0; i < 14; i++) step();

        // start pokes mid-frame are ignored
        run_frame(16'hA5C3, -1, 0, 1'b1, bits, nb, dcyc);
        chk("poke_bits", 32'(bits), 32'h0A5C3);
        chk("poke_done_cycle", 32'(dcyc), 32'd18);
        for (int i = 0; i < 3; i++) step();
        chk("poke_no_second_frame", 32'(p_valid), 32'd0);

        // Reset while bit 7 is presented, with start held alongside rst
        start = 1'b1; din = 16'hA5C3; step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1; start = 1'b1;
        step();
        chk("midrst_outputs", 32'({p_valid, p_busy, p_done, p_out, p_last}), 32'd0);
        rst = 1'b0; start = 1'b0;
        step();
        chk("midrst_start_ignored", 32'({p_valid, p_done}), 32'd0);
        run_frame(16'h00F0, -1, 0, 1'b0, bits, nb, dcyc);
        chk("after_rst_bits", 32'(bits), 32'h000F0);
        chk("after_rst_done", 32'(dcyc), 32'd18);

        // Back-to-back on the no-parity instance: restart in the done cycle
        start = 1'b1; din = 16'h8000; step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("b2b_msb_last", 32'({n_valid, n_out, n_last}), 32'b111);
        step();
        chk("b2b_done", 32'({n_done, n_valid}), 32'b10);
        start = 1'b1; din = 16'h0003;
        step();
        start = 1'b0;
        chk("b2b_second_first", 32'({n_valid, n_out, n_done, n_busy}), 32'b1101);
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 5) == 0);
            din       = 16'($urandom);
            bit_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; start = 1'b0; bit_ready = 1'b1;
        for (int i = 0; i < 25; i++) step();
        chk("final_idle", 32'({p_busy, n_busy}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
